// File: rtl/ws_input_feeder.sv
// rtl/ws_input_feeder.sv - weight-stationary systolic array feeder
// Captures a 4x4 weight tile, shifts it into the array, then streams skewed feature rows.
module ws_input_feeder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_w_valid,
  input  logic [4*DATA_WIDTH-1:0] i_w_data,
  output logic                    o_w_ready,
  input  logic                    i_f_valid,
  input  logic [4*DATA_WIDTH-1:0] i_f_data,
  input  logic                    i_f_last,
  output logic                    o_f_ready,
  output logic                    o_start,
  output logic [DATA_WIDTH-1:0]   o_w_col_1,
  output logic [DATA_WIDTH-1:0]   o_w_col_2,
  output logic [DATA_WIDTH-1:0]   o_w_col_3,
  output logic [DATA_WIDTH-1:0]   o_w_col_4,
  output logic [DATA_WIDTH-1:0]   o_f_row_1,
  output logic [DATA_WIDTH-1:0]   o_f_row_2,
  output logic [DATA_WIDTH-1:0]   o_f_row_3,
  output logic [DATA_WIDTH-1:0]   o_f_row_4,
  output logic [3:0]              o_f_vld,
  output logic                    o_done
);

  typedef enum logic [2:0] {
    IDLE, WCOL, START, LOAD, STREAM, DRAIN, DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [1:0]              cnt;
  logic [1:0]              cnt_nxt;
  logic [4*DATA_WIDTH-1:0] w_mem [4];
  logic [4*DATA_WIDTH-1:0] load_row;
  logic [1:0]              w_idx;
  logic                    w_acc;
  logic                    f_acc;
  logic                    shift_en;
  logic [DATA_WIDTH-1:0]   row_out [4];
  logic [3:0]              vld_out;

  // One counter serves as weight row index, LOAD step and DRAIN step.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    o_w_ready = 1'b0;
    o_f_ready = 1'b0;
    o_start   = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        o_w_ready = 1'b1;
        if (i_w_valid) begin
          state_nxt = WCOL;
          cnt_nxt   = 2'd1;
        end
      end
      WCOL: begin
        o_w_ready = 1'b1;
        if (i_w_valid) begin
          cnt_nxt = cnt + 2'd1;
          if (cnt == 2'd3) state_nxt = START;
        end
      end
      START: begin
        o_start   = 1'b1;
        cnt_nxt   = 2'd0;
        state_nxt = LOAD;
      end
      LOAD: begin
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) state_nxt = STREAM;
      end
      STREAM: begin
        o_f_ready = 1'b1;
        if (i_f_valid && i_f_last) begin
          state_nxt = DRAIN;
          cnt_nxt   = 2'd0;
        end
      end
      DRAIN: begin
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign w_acc = o_w_ready & i_w_valid;
  assign w_idx = (state == IDLE) ? 2'd0 : cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) w_mem[i] <= '0;
    end else if (w_acc) begin
      w_mem[w_idx] <= i_w_data;
    end
  end

  // Last row first, so W[3] has travelled to array row 4 when LOAD ends.
  assign load_row  = (state == LOAD) ? w_mem[~cnt] : '0;
  assign o_w_col_1 = load_row[0*DATA_WIDTH +: DATA_WIDTH];
  assign o_w_col_2 = load_row[1*DATA_WIDTH +: DATA_WIDTH];
  assign o_w_col_3 = load_row[2*DATA_WIDTH +: DATA_WIDTH];
  assign o_w_col_4 = load_row[3*DATA_WIDTH +: DATA_WIDTH];

  assign f_acc    = o_f_ready & i_f_valid;
  assign shift_en = (state == STREAM) || (state == DRAIN);

  // Row r is delayed r+1 cycles; an idle STREAM cycle enters as a zero bubble.
  for (genvar r = 0; r < 4; r++) begin : g_skew
    logic [DATA_WIDTH-1:0] dp [0:r];
    logic [r:0]            vp;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int s = 0; s <= r; s++) dp[s] <= '0;
        vp <= '0;
      end else if (shift_en) begin
        dp[0] <= f_acc ? i_f_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        vp[0] <= f_acc;
        for (int s = 1; s <= r; s++) begin
          dp[s] <= dp[s-1];
          vp[s] <= vp[s-1];
        end
      end else begin
        for (int s = 0; s <= r; s++) dp[s] <= '0;
        vp <= '0;
      end
    end

    assign row_out[r] = dp[r];
    assign vld_out[r] = vp[r];
  end

  assign o_f_row_1 = row_out[0];
  assign o_f_row_2 = row_out[1];
  assign o_f_row_3 = row_out[2];
  assign o_f_row_4 = row_out[3];
  assign o_f_vld   = vld_out;

endmodule

// File: tb/tb_ws_input_feeder.sv
// tb/tb_ws_input_feeder.sv - scoreboard bench for ws_input_feeder
// Expected events are scheduled by absolute cycle number; a negedge monitor retires them.
module tb_ws_input_feeder;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          w_valid = 1'b0;
  logic [4*DW-1:0] w_data = '0;
  logic          w_ready;
  logic          f_valid = 1'b0;
  logic [4*DW-1:0] f_data = '0;
  logic          f_last = 1'b0;
  logic          f_ready;
  logic          start;
  logic [DW-1:0] wc1, wc2, wc3, wc4;
  logic [DW-1:0] fr1, fr2, fr3, fr4;
  logic [3:0]    f_vld;
  logic          done;

  ws_input_feeder #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn),
    .i_w_valid(w_valid), .i_w_data(w_data), .o_w_ready(w_ready),
    .i_f_valid(f_valid), .i_f_data(f_data), .i_f_last(f_last), .o_f_ready(f_ready),
    .o_start(start),
    .o_w_col_1(wc1), .o_w_col_2(wc2), .o_w_col_3(wc3), .o_w_col_4(wc4),
    .o_f_row_1(fr1), .o_f_row_2(fr2), .o_f_row_3(fr3), .o_f_row_4(fr4),
    .o_f_vld(f_vld), .o_done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] v;
  } ev_t;

  int   total = 0;
  int   bad = 0;
  bit   in_reset = 1'b1;
  int   wb_lo = 0, wb_hi = -1, f_lo = 0, f_hi = -1;
  int   exp_start[$];
  int   exp_done[$];
  ev_t  exp_wcol[$];
  ev_t  exp_row[4][$];
  logic [31:0] jw[4];
  logic [31:0] jx[$];
  int   jgap[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  function automatic logic [DW-1:0] row_of(input int r);
    case (r)
      0: return fr1;
      1: return fr2;
      2: return fr3;
      default: return fr4;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    bit          e;
    logic [31:0] ev;
    logic [31:0] gw;
    logic [8:0]  gr;
    if (!in_reset) begin
      e = exp_start.size() > 0 && exp_start[0] == cyc;
      if (e) void'(exp_start.pop_front());
      if (e || start) chk("start", start, e);

      e = exp_done.size() > 0 && exp_done[0] == cyc;
      if (e) void'(exp_done.pop_front());
      if (e || done) chk("done", done, e);

      e  = exp_wcol.size() > 0 && exp_wcol[0].cyc == cyc;
      ev = e ? exp_wcol[0].v : 32'h0;
      if (e) void'(exp_wcol.pop_front());
      gw = {wc4, wc3, wc2, wc1};
      if (e || gw != 0) chk("w_col", gw, ev);

      for (int r = 0; r < 4; r++) begin
        e  = exp_row[r].size() > 0 && exp_row[r][0].cyc == cyc;
        ev = e ? exp_row[r][0].v : 32'h0;
        if (e) void'(exp_row[r].pop_front());
        gr = {f_vld[r], row_of(r)};
        if (e || gr != 0) chk($sformatf("f_row_%0d", r + 1), gr, {e, ev[7:0]});
      end

      chk("w_ready", w_ready, !(cyc >= wb_lo && cyc <= wb_hi));
      chk("f_ready", f_ready, (cyc >= f_lo && cyc <= f_hi));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst();
    chk("rst_w_ready", w_ready, 1);
    chk("rst_f_ready", f_ready, 0);
    chk("rst_start", start, 0);
    chk("rst_done", done, 0);
    chk("rst_f_vld", f_vld, 0);
    chk("rst_w_cols", {wc4, wc3, wc2, wc1}, 0);
    chk("rst_f_rows", {fr4, fr3, fr2, fr1}, 0);
  endtask

  task automatic noise(input bit wnoise);
    f_valid = 1'($urandom_range(0, 1));
    f_data  = $urandom;
    f_last  = 1'($urandom_range(0, 1));
    if (wnoise) begin
      w_valid = 1'($urandom_range(0, 1));
      w_data  = $urandom;
    end
  endtask

  task automatic load_weights(output int a);
    int beats = 0;
    a = 0;
    while (beats < 4) begin
      if ($urandom_range(0, 3) == 0) begin
        w_valid = 1'b0;
        w_data  = $urandom;
      end else begin
        w_valid = 1'b1;
        w_data  = jw[beats];
        beats++;
        if (beats == 4) begin
          a     = cyc;
          wb_lo = a + 1;
          wb_hi = 32'h3fffffff;
          f_lo  = a + 6;
          f_hi  = 32'h3fffffff;
          exp_start.push_back(a + 1);
          for (int k = 0; k < 4; k++) exp_wcol.push_back('{a + 2 + k, jw[3-k]});
        end
      end
      step();
    end
    w_valid = 1'b0;
  endtask

  task automatic run_job(input bit wnoise);
    int a;
    int last_cyc;
    logic [31:0] x;
    load_weights(a);
    repeat (5) begin
      noise(wnoise);
      step();
    end
    for (int i = 0; i < jx.size(); i++) begin
      repeat (jgap[i]) begin
        noise(wnoise);
        f_valid = 1'b0;
        step();
      end
      noise(wnoise);
      x       = jx[i];
      f_valid = 1'b1;
      f_data  = x;
      f_last  = (i == jx.size() - 1);
      for (int r = 0; r < 4; r++) exp_row[r].push_back('{cyc + 1 + r, {24'h0, x[r*8 +: 8]}});
      if (f_last) begin
        last_cyc = cyc;
        f_hi     = last_cyc;
        wb_hi    = last_cyc + 5;
        exp_done.push_back(last_cyc + 5);
      end
      step();
    end
    repeat (4) begin
      noise(wnoise);
      step();
    end
    f_valid = 1'b0;
    f_last  = 1'b0;
    w_valid = 1'b0;
    step();
  endtask

  task automatic flush();
    exp_start.delete();
    exp_done.delete();
    exp_wcol.delete();
    for (int r = 0; r < 4; r++) exp_row[r].delete();
    wb_lo = 0; wb_hi = -1; f_lo = 0; f_hi = -1;
  endtask

  task automatic rand_job_setup(input int n, input int maxgap);
    for (int i = 0; i < 4; i++) jw[i] = $urandom;
    jx.delete();
    jgap.delete();
    for (int i = 0; i < n; i++) begin
      jx.push_back($urandom);
      jgap.push_back($urandom_range(0, maxgap));
    end
  endtask

  initial begin
    int a;
    repeat (2) step();
    check_rst();
    rstn     = 1'b1;
    in_reset = 1'b0;
    step();

    jw[0] = 32'h04030201; jw[1] = 32'h08070605;
    jw[2] = 32'h0C0B0A09; jw[3] = 32'h100F0E0D;
    jx.delete(); jgap.delete();
    jx.push_back(32'h44332211); jgap.push_back(0);
    run_job(1'b0);

    rand_job_setup(3, 0);
    jgap[1] = 2;
    run_job(1'b1);

    rand_job_setup(2, 1);
    load_weights(a);
    repeat (3) step();
    in_reset = 1'b1;
    rstn     = 1'b0;
    #1;
    check_rst();
    flush();
    repeat (2) step();
    check_rst();
    rstn     = 1'b1;
    in_reset = 1'b0;
    step();

    for (int j = 0; j < 6; j++) begin
      rand_job_setup($urandom_range(1, 6), 3);
      run_job(1'($urandom_range(0, 1)));
    end

    repeat (3) step();
    chk("queues_drained", exp_start.size() + exp_done.size() + exp_wcol.size() +
        exp_row[0].size() + exp_row[1].size() + exp_row[2].size() + exp_row[3].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws_input_feeder.md
WS_INPUT_FEEDER -- requirements
Module: ws_input_feeder

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of every weight and feature-map element.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 i_w_valid  input  1  weight-row beat valid.
REQ-005 i_w_data  input  4*DATA_WIDTH  one weight row; element c (c=0..3) in bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-006 o_w_ready  output  1  weight beat accepted when high together with i_w_valid.
REQ-007 i_f_valid  input  1  feature vector valid.
REQ-008 i_f_data  input  4*DATA_WIDTH  one feature vector; element r (r=0..3) is destined for array row r+1.
REQ-009 i_f_last  input  1  marks the final feature vector of a job.
REQ-010 o_f_ready  output  1  feature vector accepted when high together with i_f_valid.
REQ-011 o_start  output  1  one-cycle start pulse to the systolic array.
REQ-012 o_w_col_1..o_w_col_4  output  DATA_WIDTH each  weight column inputs of the array.
REQ-013 o_f_row_1..o_f_row_4  output  DATA_WIDTH each  skewed feature-map row inputs of the array.
REQ-014 o_f_vld  output  4  per-row valid, skewed identically to o_f_row_n.
REQ-015 o_done  output  1  one-cycle pulse at end of job.

Function
REQ-016 States SHALL be IDLE, WCOL, START, LOAD, STREAM, DRAIN, DONE; reset state IDLE.
REQ-017 IDLE: o_w_ready=1; the first accepted weight beat is stored as weight row 0 and moves the state to WCOL.
REQ-018 WCOL: o_w_ready=1; beats are stored as rows 1,2,3; acceptance of row 3 moves the state to START.
REQ-019 o_w_ready SHALL be 0 in START, LOAD, STREAM, DRAIN, and DONE; i_w_valid is ignored in these states.
REQ-020 START: lasts exactly 1 cycle with o_start=1; o_start SHALL be 0 in every other state.
REQ-021 LOAD: lasts exactly 4 cycles (2-bit counter k=0..3); in cycle k, o_w_col_(c+1) SHALL equal stored W[3-k][c], so W[3] reaches array row 4 and W[0] reaches row 1.
REQ-022 o_w_col_n SHALL be 0 outside LOAD.
REQ-023 After LOAD k=3, the state SHALL move to STREAM.
REQ-024 STREAM: o_f_ready=1; o_f_ready SHALL be 0 in every other state.
REQ-025 An accepted vector x SHALL appear as o_f_row_1=x[0] one cycle later and as o_f_row_(r+1)=x[r] r+1 cycles later (row skew 1/2/3/4 cycles); o_f_vld[r] SHALL be high in the same cycle.
REQ-026 A STREAM cycle without i_f_valid SHALL inject a zero element with vld=0 into the skew chain (bubble).
REQ-027 Skew registers SHALL shift every cycle in STREAM and DRAIN and SHALL hold zero/vld=0 in all other states.
REQ-028 Accepting a vector with i_f_last=1 SHALL move the state to DRAIN.
REQ-029 DRAIN: lasts exactly 4 cycles, feeding bubbles; then the state SHALL move to DONE.
REQ-030 DONE: lasts 1 cycle with o_done=1; then the state SHALL return to IDLE.
REQ-031 Stored weights SHALL persist until overwritten by the next job's WCOL beats.
REQ-032 All data paths SHALL be pass-through with no arithmetic; widths are preserved.

Reset
REQ-033 While rstn=0, asynchronously: state=IDLE, LOAD counter=0, weight storage=0, skew registers=0.
REQ-034 Output values during reset: o_w_ready=1, o_f_ready=0, o_start=0, o_done=0, o_f_vld=0, and all o_w_col_n and o_f_row_n=0.
REQ-035 Reset asserted mid-job SHALL abort the job immediately, with no o_done pulse.

Verification
REQ-036 Load rows W0=0x04030201, W1=0x08070605, W2=0x0C0B0A09, W3=0x100F0E0D -> o_start pulses on the cycle after the 4th beat; LOAD cycles show cols {0D,0E,0F,10},{09..0C},{05..08},{01..04}.
REQ-037 Stream x=0x44332211 with last=1 -> o_f_row_1=0x11 at +1, row_2=0x22 at +2, row_3=0x33 at +3, row_4=0x44 at +4, matching o_f_vld bits; o_done pulses 1 cycle after DRAIN ends; state returns to IDLE.
REQ-038 Stream three vectors with an i_f_valid gap between vectors 1 and 2 -> the bubble appears as a zero element with vld=0 on each row at its skewed cycle; ordering of the other vectors is preserved.
REQ-039 Drive i_w_valid=1 throughout STREAM -> o_w_ready stays 0 and the stored weights are unchanged.
REQ-040 Assert rstn=0 during LOAD k=2 -> all outputs are at their reset values before the next clock edge; after release, a full new job completes correctly.
